// File: rtl/apb_pkg.sv
// Shared APB slave types and bus widths.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  // Two-state transfer FSM: waiting for a setup phase, or inside the access phase.
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

endpackage

// File: rtl/apb_slave_regfile.sv
// DEPTH x 32-bit register array: synchronous write, combinational read, synchronous clear.
// Latency: read is combinational; a write becomes visible the cycle after the write edge.
// Backpressure: none; the caller qualifies every write with we_i.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      idx_i,
  input  logic [APB_DATA_W-1:0] wdata_i,
  output logic [APB_DATA_W-1:0] rdata_o
);

  logic [APB_DATA_W-1:0] mem_q [DEPTH];

  // Clear all entries on reset, otherwise write the indexed entry when enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  // DEPTH is a power of two, so every index value addresses a real entry.
  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/apb_slave.sv
// APB slave fronting a DEPTH-entry register file, with WAIT_CYCLES wait states per access.
// Latency: every transfer takes 2+WAIT_CYCLES cycles (setup, waits, completing access cycle).
// Backpressure: pready_o is held low for WAIT_CYCLES access cycles; psel_i dropping aborts the transfer.
module apb_slave
  import apb_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic [APB_ADDR_W-1:0] paddr_i,
  input  logic                  pwrite_i,
  input  logic [APB_DATA_W-1:0] pwdata_i,
  output logic                  pready_o,
  output logic [APB_DATA_W-1:0] prdata_o,
  output logic                  pslverr_o
);

  localparam int                  IDX_W = $clog2(DEPTH);
  // First byte address past the register file; anything at or above it is an error.
  localparam logic [APB_ADDR_W-1:0] ADDR_LIMIT = APB_ADDR_W'(4 * DEPTH);

  apb_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [APB_ADDR_W-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [APB_DATA_W-1:0] wdata_q, wdata_d;

  logic                  done;
  logic                  addr_err;
  logic                  reg_we;
  logic [APB_DATA_W-1:0] reg_rdata;

  // Next-state logic: latch the setup phase, count wait states, complete or abort.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // psel with penable already high is not a valid setup phase and is ignored.
        if (psel_i && !penable_i) begin
          state_d = ACCESS;
          addr_d  = paddr_i;
          write_d = pwrite_i;
          wdata_d = pwdata_i;
          cnt_d   = 4'(WAIT_CYCLES);
        end
      end
      ACCESS: begin
        if (!psel_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (penable_i) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched-transfer registers; reset wins over any bus activity.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
    end
  end

  // Error decode works on the latched address so mid-transfer bus changes cannot affect it.
  assign addr_err  = (addr_q[1:0] != 2'b00) || (addr_q >= ADDR_LIMIT);
  assign pready_o  = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign pslverr_o = pready_o && addr_err;
  assign prdata_o  = (pready_o && !write_q && !addr_err) ? reg_rdata : '0;
  // done already implies pready_o; reset is folded in so a write never races the clear.
  assign reg_we    = done && write_q && !addr_err && !reset;

  apb_slave_regfile #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we_i    (reg_we),
    .idx_i   (addr_q[IDX_W+1:2]),
    .wdata_i (wdata_q),
    .rdata_o (reg_rdata)
  );

endmodule

// File: tb/tb_apb_slave.sv
// Self-checking bench for apb_slave: transaction-level model plus directed literal checks.
// Latency: main instance uses WAIT_CYCLES=2 (4-cycle transfers); second instance uses 0 (2-cycle).
// Backpressure: the bench always waits out the modelled wait states; no waits depend on the DUT.
module tb_apb_slave;

  localparam int DEPTH = 16;
  localparam int WT    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic        pready, pslverr;
  logic [31:0] prdata;

  logic        psel0, penable0, pwrite0;
  logic [31:0] paddr0, pwdata0;
  logic        pready0, pslverr0;
  logic [31:0] prdata0;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: register contents and the outputs expected in the current cycle.
  logic [31:0] mem [DEPTH];
  logic        exp_pready, exp_pslverr;
  logic [31:0] exp_prdata;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;

  apb_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(WT)) dut (
    .clk       (clk),
    .reset     (reset),
    .psel_i    (psel),
    .penable_i (penable),
    .paddr_i   (paddr),
    .pwrite_i  (pwrite),
    .pwdata_i  (pwdata),
    .pready_o  (pready),
    .prdata_o  (prdata),
    .pslverr_o (pslverr)
  );

  apb_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk       (clk),
    .reset     (reset),
    .psel_i    (psel0),
    .penable_i (penable0),
    .paddr_i   (paddr0),
    .pwrite_i  (pwrite0),
    .pwdata_i  (pwdata0),
    .pready_o  (pready0),
    .prdata_o  (prdata0),
    .pslverr_o (pslverr0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp_zero();
    exp_pready  = 1'b0;
    exp_pslverr = 1'b0;
    exp_prdata  = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  endtask

  // Every cycle, the main DUT's outputs must match the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pready_o", {31'b0, pready}, {31'b0, exp_pready});
      chk("pslverr_o", {31'b0, pslverr}, {31'b0, exp_pslverr});
      chk("prdata_o", prdata, exp_prdata);
    end
  end

  task automatic idle(input int n);
    psel    = 1'b0;
    penable = 1'b0;
    set_exp_zero();
    repeat (n) step();
  endtask

  // One APB transfer on the main DUT. drop_at>0 releases psel in that access cycle.
  // Returns what the DUT showed when pready was high, and the number of cycles used.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input int drop_at, output logic [31:0] rd,
                      output logic rdy_seen, output logic err_seen, output int cycles);
    logic e;
    int   idx;
    e        = (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
    idx      = int'(a[5:2]);
    rd       = '0;
    rdy_seen = 1'b0;
    err_seen = 1'b0;
    cycles   = 1;
    psel    = 1'b1;
    penable = 1'b0;
    paddr   = a;
    pwrite  = w;
    pwdata  = d;
    set_exp_zero();
    step();
    for (int k = 1; k <= WT + 1; k++) begin
      cycles++;
      // Scramble the setup-phase signals: the transfer must use the latched copies.
      paddr  = $urandom;
      pwdata = $urandom;
      pwrite = 1'($urandom_range(0, 1));
      if (k == drop_at) begin
        psel    = 1'b0;
        penable = 1'b0;
      end else begin
        penable = 1'b1;
      end
      exp_pready  = (k == WT + 1);
      exp_pslverr = exp_pready && e;
      exp_prdata  = (exp_pready && !w && !e) ? mem[idx] : 32'h0;
      if (pready) begin
        rdy_seen = 1'b1;
        rd       = prdata;
      end
      if (pslverr) err_seen = 1'b1;
      step();
      if (k == drop_at) break;
      if (exp_pready && w && !e) mem[idx] = d;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        rs, es;
    int          cyc;

    reset = 1'b1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    psel0 = 1'b0; penable0 = 1'b0; pwrite0 = 1'b0; paddr0 = '0; pwdata0 = '0;
    model_clear();
    set_exp_zero();
    step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    idle(1);

    // Write 0xDEADBEEF to 0x8, then read it back.
    xfer(32'h8, 1'b1, 32'hDEADBEEF, 0, rd, rs, es, cyc);
    chk("wr8_cycles", 32'(cyc), 32'd4);
    chk("wr8_ready", {31'b0, rs}, 32'd1);
    chk("wr8_slverr", {31'b0, es}, 32'd0);
    chk("model_mem2", mem[2], 32'hDEADBEEF);
    idle(1);
    xfer(32'h8, 1'b0, 32'h0, 0, rd, rs, es, cyc);
    chk("rd8_data", rd, 32'hDEADBEEF);

    // Back-to-back write then read of 0x4.
    xfer(32'h4, 1'b1, 32'h11, 0, rd, rs, es, cyc);
    chk("b2b_wr_cycles", 32'(cyc), 32'd4);
    xfer(32'h4, 1'b0, 32'h0, 0, rd, rs, es, cyc);
    chk("b2b_rd_cycles", 32'(cyc), 32'd4);
    chk("b2b_rd_data", rd, 32'h11);

    // Top entry is valid; one past it and a misaligned address are errors.
    xfer(32'h3C, 1'b1, 32'hCAFEF00D, 0, rd, rs, es, cyc);
    xfer(32'h3C, 1'b0, 32'h0, 0, rd, rs, es, cyc);
    chk("rd3c_data", rd, 32'hCAFEF00D);
    chk("rd3c_slverr", {31'b0, es}, 32'd0);
    xfer(32'h40, 1'b0, 32'h0, 0, rd, rs, es, cyc);
    chk("rd40_slverr", {31'b0, es}, 32'd1);
    chk("rd40_data", rd, 32'h0);
    xfer(32'h6, 1'b1, 32'hFFFFFFFF, 0, rd, rs, es, cyc);
    chk("wr6_slverr", {31'b0, es}, 32'd1);
    xfer(32'h40, 1'b1, 32'h12345678, 0, rd, rs, es, cyc);
    chk("wr40_slverr", {31'b0, es}, 32'd1);
    xfer(32'h4, 1'b0, 32'h0, 0, rd, rs, es, cyc);
    chk("rd4_after_err", rd, 32'h11);
    xfer(32'h0, 1'b0, 32'h0, 0, rd, rs, es, cyc);
    chk("rd0_after_err", rd, 32'h0);

    // psel+penable in IDLE must not start a transfer.
    psel = 1'b1; penable = 1'b1; paddr = 32'h8; pwrite = 1'b1; pwdata = 32'h77;
    set_exp_zero();
    step();
    idle(1);
    xfer(32'h8, 1'b0, 32'h0, 0, rd, rs, es, cyc);
    chk("ign_cycles", 32'(cyc), 32'd4);
    chk("ign_data", rd, 32'hDEADBEEF);

    // psel dropped in the 2nd access cycle aborts the write to 0xC.
    xfer(32'hC, 1'b1, 32'h55, 2, rd, rs, es, cyc);
    chk("abort_ready", {31'b0, rs}, 32'd0);
    idle(1);
    xfer(32'hC, 1'b0, 32'h0, 0, rd, rs, es, cyc);
    chk("abort_rdC", rd, 32'h0);

    // Reset during the access phase of a write to 0x0.
    psel = 1'b1; penable = 1'b0; paddr = 32'h0; pwrite = 1'b1; pwdata = 32'hA5A5A5A5;
    set_exp_zero();
    step();
    penable = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_clear();
    psel = 1'b0; penable = 1'b0;
    step();
    xfer(32'h0, 1'b0, 32'h0, 0, rd, rs, es, cyc);
    chk("rst_rd0", rd, 32'h0);
    xfer(32'h8, 1'b0, 32'h0, 0, rd, rs, es, cyc);
    chk("rst_rd8", rd, 32'h0);
    idle(2);

    // Zero-wait-state instance: write then back-to-back read of 0x0.
    chk("w0_reset_ready", {31'b0, pready0}, 32'd0);
    psel0 = 1'b1; penable0 = 1'b0; paddr0 = 32'h0; pwrite0 = 1'b1; pwdata0 = 32'h5A;
    step();
    penable0 = 1'b1; paddr0 = 32'hFF; pwdata0 = 32'h0;
    chk("w0_wr_ready", {31'b0, pready0}, 32'd1);
    step();
    penable0 = 1'b0; pwrite0 = 1'b0; paddr0 = 32'h0;
    chk("w0_setup_ready", {31'b0, pready0}, 32'd0);
    step();
    penable0 = 1'b1;
    chk("w0_rd_ready", {31'b0, pready0}, 32'd1);
    chk("w0_rd_data", prdata0, 32'h5A);
    chk("w0_rd_slverr", {31'b0, pslverr0}, 32'd0);
    step();
    psel0 = 1'b0; penable0 = 1'b0;
    chk("w0_done_ready", {31'b0, pready0}, 32'd0);
    chk("w0_done_data", prdata0, 32'h0);
    step();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/apb_slave.md
APB_SLAVE -- requirements
Module: apb_slave

Interface
REQ-001 Parameter DEPTH, default 16, number of 32-bit registers (power of two, 2..256).
REQ-002 Parameter WAIT_CYCLES, default 2, wait states inserted in every access phase (0..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 psel_i  input  1  APB select from master.
REQ-006 penable_i  input  1  APB enable; high marks access phase.
REQ-007 paddr_i  input  32  byte address.
REQ-008 pwrite_i  input  1  1 = write, 0 = read.
REQ-009 pwdata_i  input  32  write data.
REQ-010 pready_o  output  1  transfer-complete indication.
REQ-011 prdata_o  output  32  read data.
REQ-012 pslverr_o  output  1  transfer error, meaningful only with pready_o.

Function
REQ-013 The FSM SHALL have two states: IDLE and ACCESS.
REQ-014 In IDLE, an edge with psel_i=1, penable_i=0 (setup) SHALL latch paddr_i, pwrite_i and pwdata_i, load wait counter with WAIT_CYCLES, and go to ACCESS.
REQ-015 In ACCESS, each edge with psel_i=1, penable_i=1 and counter != 0 SHALL decrement the counter.
REQ-016 pready_o SHALL be 1 exactly when state = ACCESS and counter = 0; a transfer therefore takes 2+WAIT_CYCLES cycles.
REQ-017 Completion edge (ACCESS, psel_i=1, penable_i=1, pready_o=1) SHALL return FSM to IDLE; a new setup is accepted on the following edge (back-to-back).
REQ-018 Register index SHALL be latched paddr[log2(DEPTH)+1:2].
REQ-019 Error condition: latched paddr[1:0] != 0 or latched paddr >= 4*DEPTH.
REQ-020 pslverr_o SHALL equal pready_o AND error condition; it SHALL be 0 otherwise.
REQ-021 A non-error write SHALL update the indexed register with latched pwdata on the completion edge only; error writes SHALL change no register.
REQ-022 prdata_o SHALL show the indexed register during a read while pready_o=1, and 0 at all other times including error reads.
REQ-023 psel_i dropping to 0 while in ACCESS SHALL abort to IDLE with no register update.
REQ-024 penable_i=1 while in IDLE SHALL be ignored (no state change).
REQ-025 Setup-phase values of paddr_i/pwrite_i/pwdata_i changing during ACCESS SHALL NOT affect the transfer (latched values rule).

Reset
REQ-026 reset SHALL force IDLE, counter 0, all registers 0, pready_o=0, pslverr_o=0, prdata_o=0 on the next edge.
REQ-027 reset asserted mid-transfer SHALL abort it with no register write; reset takes priority over every other event.

Structure
REQ-028 Package apb_pkg SHALL hold the state enum (IDLE, ACCESS) and constants APB_ADDR_W=32, APB_DATA_W=32.
REQ-029 Register storage SHALL be a sub-module apb_slave_regfile (synchronous write, combinational read, synchronous clear).

Verification
REQ-030 Write 0xDEADBEEF to 0x8, WAIT_CYCLES=2 -> pready_o high in the 4th cycle after setup, pslverr_o=0; subsequent read of 0x8 returns 0xDEADBEEF.
REQ-031 Back-to-back write 0x4=0x11, read 0x4 with no idle cycle -> read returns 0x00000011, each transfer 4 cycles.
REQ-032 Read 0x40 (DEPTH=16) and write to 0x6 -> pslverr_o=1 with pready_o, prdata_o=0, no register changes.
REQ-033 Write to 0xC, psel_i dropped in 2nd access cycle -> FSM IDLE, register 0xC remains 0, pready_o never asserted.
REQ-034 Reset asserted during access phase of write 0x0=0xA5A5A5A5 -> outputs 0 next edge, read of 0x0 after reset returns 0.
REQ-035 WAIT_CYCLES=0 build, read 0x0 -> pready_o high in first access cycle, transfer takes 2 cycles.
